// File: rtl/pool_pkg.sv
// Shared definitions for the pooling controller: FSM state encoding, frame
// length default and the beat indices that close each pooled line.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_e;

  localparam int unsigned CNT_MAX    = 67;
  localparam int unsigned LINE0_BEAT = 34;
  localparam int unsigned LINE1_BEAT = 50;
  localparam int unsigned LINE2_BEAT = 66;

endpackage

// File: rtl/pool_ctrl_if.sv
// Handshake/status bundle between the convolution engine side and the
// pooling controller; clock and reset are carried separately.
interface pool_ctrl_if #(
  parameter int unsigned CNT_W = 7
);
  logic             start;
  logic             abort;
  logic             conv_vld;
  logic             conv_rdy;
  logic [CNT_W-1:0] cnt;
  logic             in_vld;
  logic             lin_vld;
  logic [1:0]       lin_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, conv_vld,
    input  conv_rdy, cnt, in_vld, lin_vld, lin_idx, busy, done
  );

  modport slave (
    input  start, abort, conv_vld,
    output conv_rdy, cnt, in_vld, lin_vld, lin_idx, busy, done
  );
endinterface

// File: rtl/pool_ctrl.sv
// Frame sequencer for the pooling datapath: counts accepted pixel beats and
// flags the end of each pooled line one cycle after its closing beat.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int unsigned CNT_MAX = pool_pkg::CNT_MAX,
  parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  pool_ctrl_if.slave   bus
);

  pool_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lin_vld_q, lin_vld_d;
  logic [1:0]       lin_idx_q, lin_idx_d;
  logic             done_q, done_d;
  logic             accept;

  // Abort wins over a beat presented in the same cycle.
  assign accept = (state_q == RUN) && bus.conv_vld && !bus.abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lin_vld_d = 1'b0;
    lin_idx_d = lin_idx_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (cnt_q == CNT_W'(CNT_MAX)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Line flags follow the accepted beat index, so stalls never move them.
          if (cnt_q == CNT_W'(LINE0_BEAT)) begin
            lin_vld_d = 1'b1;
            lin_idx_d = 2'd0;
          end else if (cnt_q == CNT_W'(LINE1_BEAT)) begin
            lin_vld_d = 1'b1;
            lin_idx_d = 2'd1;
          end else if (cnt_q == CNT_W'(LINE2_BEAT)) begin
            lin_vld_d = 1'b1;
            lin_idx_d = 2'd2;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lin_vld_q <= 1'b0;
      lin_idx_q <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lin_vld_q <= lin_vld_d;
      lin_idx_q <= lin_idx_d;
      done_q    <= done_d;
    end
  end

  assign bus.conv_rdy = (state_q == RUN);
  assign bus.in_vld   = accept;
  assign bus.cnt      = cnt_q;
  assign bus.lin_vld  = lin_vld_q;
  assign bus.lin_idx  = lin_idx_q;
  assign bus.busy     = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: full frames with and without stalls, aborts,
// ignored starts and mid-frame reset.
module tb_pool_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  pool_ctrl_if #(.CNT_W(7)) bus ();

  pool_ctrl #(.CNT_MAX(67), .CNT_W(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lin_pulses = 0;
  int done_pulses = 0;
  logic [1:0] last_lin_idx = 2'd0;

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.lin_vld === 1'b1) begin
      lin_pulses++;
      last_lin_idx = bus.lin_idx;
    end
    if (bus.done === 1'b1) done_pulses++;
  endtask

  task automatic clear_obs();
    lin_pulses  = 0;
    done_pulses = 0;
  endtask

  task automatic wait_cnt(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (bus.conv_rdy === 1'b1 && bus.cnt === 7'(target)) hit = 1'b1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_cnt: cnt=%0d never reached, required %0d", bus.cnt, target);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.conv_vld = 1'b1;
    rst_n = 1'b1;
    step(); step();
    checks++; if (bus.cnt !== 7'd0)      begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt); end
    checks++; if (bus.conv_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", bus.conv_rdy); end
    checks++; if (bus.in_vld !== 1'b0)   begin errors++; $display("FAIL reset_in_vld: got %b want 0", bus.in_vld); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.lin_vld !== 1'b0)  begin errors++; $display("FAIL reset_lin_vld: got %b want 0", bus.lin_vld); end
    checks++; if (bus.lin_idx !== 2'd0)  begin errors++; $display("FAIL reset_lin_idx: got %0d want 0", bus.lin_idx); end
    rst_n = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b want 0", bus.busy); end
    bus.conv_vld = 1'b0;
  endtask

  task automatic test_full_frame(input bit stall);
    int exp_cnt, prev_beat, busy_cyc, stalls, lin_n, beat67_cyc;
    bit fin, running;
    logic exp_lin;
    logic [1:0] exp_idx;
    exp_cnt = 0; prev_beat = -1; busy_cyc = 0; stalls = 0; lin_n = 0;
    beat67_cyc = -1; fin = 1'b0;
    clear_obs();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      exp_lin = (prev_beat == 34 || prev_beat == 50 || prev_beat == 66);
      checks++;
      if (bus.lin_vld !== exp_lin) begin
        errors++; $display("FAIL frame_lin_vld s=%0d cyc=%0d: got %b want %b", stall, cyc, bus.lin_vld, exp_lin);
      end
      if (exp_lin) begin
        lin_n++;
        exp_idx = (prev_beat == 34) ? 2'd0 : (prev_beat == 50) ? 2'd1 : 2'd2;
        checks++;
        if (bus.lin_idx !== exp_idx) begin
          errors++; $display("FAIL frame_lin_idx s=%0d beat=%0d: got %0d want %0d", stall, prev_beat, bus.lin_idx, exp_idx);
        end
      end
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin
        fin = 1'b1;
        checks++;
        if (beat67_cyc < 0 || cyc != beat67_cyc + 2) begin
          errors++; $display("FAIL frame_done_time s=%0d: done at %0d want %0d", stall, cyc, beat67_cyc + 2);
        end
      end
      running = (beat67_cyc < 0) && !fin;
      bus.conv_vld = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checks++;
      if (bus.conv_rdy !== running) begin
        errors++; $display("FAIL frame_rdy s=%0d cyc=%0d: got %b want %b", stall, cyc, bus.conv_rdy, running);
      end
      checks++;
      if (bus.in_vld !== (running && bus.conv_vld)) begin
        errors++; $display("FAIL frame_in_vld s=%0d cyc=%0d: got %b want %b", stall, cyc, bus.in_vld, running && bus.conv_vld);
      end
      prev_beat = -1;
      if (running) begin
        checks++;
        if (bus.cnt !== 7'(exp_cnt)) begin
          errors++; $display("FAIL frame_cnt s=%0d cyc=%0d: got %0d want %0d", stall, cyc, bus.cnt, exp_cnt);
        end
        if (bus.conv_vld) begin
          prev_beat = exp_cnt;
          if (exp_cnt == 67) begin beat67_cyc = cyc; exp_cnt = 0; end
          else exp_cnt++;
        end else begin
          stalls++;
        end
      end
      step();
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL frame_timeout s=%0d: done never seen, want 1", stall); end
    checks++;
    if (busy_cyc != 69 + stalls) begin
      errors++; $display("FAIL frame_busy_len s=%0d: got %0d want %0d", stall, busy_cyc, 69 + stalls);
    end
    checks++;
    if (lin_n != 3) begin errors++; $display("FAIL frame_lin_count s=%0d: got %0d want 3", stall, lin_n); end
    bus.conv_vld = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt !== 7'd0) begin
      errors++; $display("FAIL frame_end_idle s=%0d: busy=%b done=%b cnt=%0d want 0 0 0", stall, bus.busy, bus.done, bus.cnt);
    end
  endtask

  task automatic test_abort_mid();
    clear_obs();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.conv_vld = 1'b1;
    wait_cnt(40);
    checks++;
    if (lin_pulses != 1 || last_lin_idx !== 2'd0) begin
      errors++; $display("FAIL abort40_pre_lin: pulses=%0d idx=%0d want 1 0", lin_pulses, last_lin_idx);
    end
    bus.abort = 1'b1;
    #1;
    checks++; if (bus.in_vld !== 1'b0) begin errors++; $display("FAIL abort40_in_vld: got %b want 0", bus.in_vld); end
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.cnt !== 7'd0 || bus.conv_rdy !== 1'b0) begin
      errors++; $display("FAIL abort40_idle: busy=%b cnt=%0d rdy=%b want 0 0 0", bus.busy, bus.cnt, bus.conv_rdy);
    end
    clear_obs();
    repeat (40) step();
    checks++;
    if (lin_pulses != 0 || done_pulses != 0) begin
      errors++; $display("FAIL abort40_after: lin=%0d done=%0d want 0 0", lin_pulses, done_pulses);
    end
    bus.conv_vld = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit got_done;
    clear_obs();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.conv_vld = 1'b1;
    wait_cnt(10);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    checks++;
    if (bus.cnt !== 7'd11 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL start_in_run: cnt=%0d busy=%b want 11 1", bus.cnt, bus.busy);
    end
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      if (bus.done === 1'b1) got_done = 1'b1;
      else step();
    end
    checks++;
    if (!got_done) begin errors++; $display("FAIL start_done_timeout: done=%b want 1", bus.done); end
    bus.start = 1'b1; step(); bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.conv_rdy !== 1'b0) begin
      errors++; $display("FAIL start_in_done: busy=%b rdy=%b want 0 0", bus.busy, bus.conv_rdy);
    end
    repeat (5) step();
    checks++;
    if (done_pulses != 1 || lin_pulses != 3 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL start_one_frame: done=%0d lin=%0d busy=%b want 1 3 0", done_pulses, lin_pulses, bus.busy);
    end
    bus.conv_vld = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_obs();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.conv_vld = 1'b1;
    wait_cnt(50);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    checks++;
    if (bus.cnt !== 7'd0 || bus.busy !== 1'b0 || bus.conv_rdy !== 1'b0 || bus.in_vld !== 1'b0 ||
        bus.lin_vld !== 1'b0 || bus.done !== 1'b0 || bus.lin_idx !== 2'd0) begin
      errors++;
      $display("FAIL rst50_outputs: cnt=%0d busy=%b rdy=%b in_vld=%b lin=%b done=%b idx=%0d want all 0",
               bus.cnt, bus.busy, bus.conv_rdy, bus.in_vld, bus.lin_vld, bus.done, bus.lin_idx);
    end
    repeat (20) step();
    checks++;
    if (lin_pulses != 1 || done_pulses != 0) begin
      errors++; $display("FAIL rst50_after: lin=%0d done=%0d want 1 0", lin_pulses, done_pulses);
    end
    bus.conv_vld = 1'b0;
  endtask

  task automatic test_abort_at_34();
    clear_obs();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.conv_vld = 1'b1;
    wait_cnt(34);
    bus.abort = 1'b1;
    #1;
    checks++; if (bus.in_vld !== 1'b0) begin errors++; $display("FAIL abort34_in_vld: got %b want 0", bus.in_vld); end
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.lin_vld !== 1'b0 || bus.busy !== 1'b0 || bus.cnt !== 7'd0) begin
      errors++; $display("FAIL abort34_state: lin=%b busy=%b cnt=%0d want 0 0 0", bus.lin_vld, bus.busy, bus.cnt);
    end
    checks++; if (lin_pulses != 0) begin errors++; $display("FAIL abort34_lin_count: got %0d want 0", lin_pulses); end
    bus.conv_vld = 1'b0;
    step();
  endtask

  task automatic test_abort_idle_drain();
    clear_obs();
    bus.abort = 1'b1; bus.start = 1'b1;
    step();
    bus.abort = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.conv_rdy !== 1'b1) begin
      errors++; $display("FAIL abort_idle: busy=%b rdy=%b want 1 1", bus.busy, bus.conv_rdy);
    end
    bus.conv_vld = 1'b1;
    wait_cnt(67);
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.conv_rdy !== 1'b0 || bus.cnt !== 7'd0) begin
      errors++; $display("FAIL drain_state: busy=%b rdy=%b cnt=%0d want 1 0 0", bus.busy, bus.conv_rdy, bus.cnt);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b0 || done_pulses != 0) begin
      errors++; $display("FAIL abort_drain: busy=%b done=%0d want 0 0", bus.busy, done_pulses);
    end
    bus.conv_vld = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.conv_vld = 1'b0;
    test_reset();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_abort_mid();
    test_start_ignored();
    test_reset_mid();
    test_abort_at_34();
    test_abort_idle_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter CNT_MAX, default 67: index of the last beat in a frame; a frame is beats 0..CNT_MAX.
REQ-002 Parameter CNT_W, default $clog2(CNT_MAX+1) = 7: width of the beat counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high (rst_n=1 resets), despite the name.
REQ-005 start  input  1  one-cycle frame start request.
REQ-006 abort  input  1  cancels the frame in progress.
REQ-007 conv_vld  input  1  the convolution engine presents one D1/D2/D3 pixel beat this cycle.
REQ-008 conv_rdy  output  1  controller accepts a beat this cycle; high only in RUN.
REQ-009 cnt  output  CNT_W  beat index driven to the pooling datapath cnt input.
REQ-010 in_vld  output  1  beat accepted (conv_vld && conv_rdy); drives the pooling datapath in_vld.
REQ-011 lin_vld  output  1  one-cycle pulse: pooled 3-pixel line on the datapath outputs is valid.
REQ-012 lin_idx  output  2  pooled line number 0..2, qualified by lin_vld.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle pulse at normal frame completion.

Function
REQ-015 FSM states are IDLE, RUN, DRAIN and DONE; the state register is encoded in 2 bits.
REQ-016 IDLE: cnt=0 and conv_rdy=0; start=1 -> RUN on the next cycle.
REQ-017 RUN: conv_rdy=1; in_vld=conv_vld combinationally; on an accepted beat, cnt increments by 1; conv_vld=0 holds cnt (stall) for any length.
REQ-018 RUN: an accepted beat with cnt==CNT_MAX -> DRAIN; cnt wraps to 0 in the same edge.
REQ-019 DRAIN lasts exactly 1 cycle with conv_rdy=0, then -> DONE.
REQ-020 DONE lasts 1 cycle with done=1, then -> IDLE; a start in DONE is ignored.
REQ-021 start is ignored in RUN, DRAIN and DONE; it is not queued.
REQ-022 abort=1 in RUN or DRAIN -> IDLE next cycle with cnt=0 and no done pulse; abort has priority over beat acceptance in the same cycle (in_vld=0).
REQ-023 abort in IDLE or DONE has no effect.
REQ-024 lin_vld is registered: it goes high for the one cycle after the accepted beat cnt==34, 50 or 66, with lin_idx=0, 1 or 2 respectively, matching the datapath's 1-cycle register latency.
REQ-025 lin_vld and lin_idx are decoded from the accepted beat index, not from cycle count, so stalls never shift them.
REQ-026 lin_vld is suppressed if abort coincides with the triggering beat.
REQ-027 lin_idx holds its last value when lin_vld=0.
REQ-028 The counter compare uses CNT_W-bit unsigned arithmetic; cnt never exceeds CNT_MAX.

Reset
REQ-029 When rst_n=1 at a clock edge: state=IDLE, cnt=0, lin_vld=0, lin_idx=0, done=0; busy, conv_rdy and in_vld therefore read 0.
REQ-030 Reset mid-frame discards the frame with no done or lin_vld pulse; reset overrides start, abort and conv_vld.

Structure
REQ-031 A shared package pool_pkg holds the FSM state typedef, CNT_MAX, and the line-end beat constants 34/50/66.
REQ-032 Single module, no sub-module; it sits alongside, and drives, the pooling datapath cnt and in_vld inputs.

Verification
REQ-033 Reset, then start with conv_vld held at 1 -> cnt steps 0..67 over 68 cycles; lin_vld pulses at 3 cycles (idx 0, 1, 2), one cycle after cnt=34, 50 and 66 respectively; done pulses 2 cycles after beat 67; busy is high for 69 cycles.
REQ-034 Random conv_vld stalls (50% duty) -> cnt sequence and lin_vld/lin_idx order are identical to REQ-033; cnt holds on every stall cycle.
REQ-035 abort at cnt=40 -> IDLE and cnt=0 next cycle; lin_idx 0 was emitted, no further lin_vld, no done.
REQ-036 start pulsed at cnt=10 and again in the DONE cycle -> both ignored; exactly one frame completes.
REQ-037 rst_n=1 asserted at cnt=50 together with conv_vld=1 -> all outputs 0 next cycle; lin_idx 2 is never emitted.
REQ-038 abort coincident with the accepted beat cnt=34 -> in_vld=0 and no lin_vld; FSM in IDLE.
